// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter step used when training the table.
package bp_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [CNT_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  // Moves one step toward the observed direction, sticking at either end.
  function automatic logic [CNT_W-1:0] bp_next(input logic [CNT_W-1:0] cnt,
                                               input logic             taken);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Branch history table of 2-bit saturating counters with one registered
// read port and one training (write-by-update) port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int               IDX_BITS    = 6,
  parameter logic [CNT_W-1:0] RESET_STATE = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [CNT_W-1:0]    rd_cnt_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  logic [CNT_W-1:0] bht_q [ENTRIES];
  logic [CNT_W-1:0] rdCnt_q;

  // Non-blocking update means a same-index read sees the pre-update counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= RESET_STATE;
      end
      rdCnt_q <= '0;
    end else begin
      if (wr_en_i) begin
        bht_q[wr_idx_i] <= bp_next(bht_q[wr_idx_i], wr_taken_i);
      end
      if (rd_en_i) begin
        rdCnt_q <= bht_q[rd_idx_i];
      end
    end
  end

  assign rd_cnt_o = rdCnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch-direction predictor (BHT of 2-bit counters) for the 5-stage
// MIPS pipeline. Define BP_PERF_CNT_EN to add br_cnt/miss_cnt perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int               IDX_BITS    = 6,
  parameter logic [CNT_W-1:0] RESET_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic        mis_taken
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
`endif
);

  logic             lkEn;
  logic [CNT_W-1:0] rdCnt;
  logic             predValid_q, predValid_d;
  logic             misPred_q, misPred_d;
  logic             misTaken_q, misTaken_d;
  logic             unusedBits;

  assign lkEn = lk_valid && !if_stall;

  // The table only refreshes its read register on an unstalled lookup, so
  // pred_taken naturally holds while IF is stalled.
  bp_counter_table #(
    .IDX_BITS    (IDX_BITS),
    .RESET_STATE (RESET_STATE)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (lkEn),
    .rd_idx_i   (lk_pc[IDX_BITS+1:2]),
    .rd_cnt_o   (rdCnt),
    .wr_en_i    (upd_valid),
    .wr_idx_i   (upd_pc[IDX_BITS+1:2]),
    .wr_taken_i (upd_taken)
  );

  always_comb begin
    predValid_d = predValid_q;
    if (!if_stall) predValid_d = lk_valid;
    misPred_d  = upd_valid && (upd_taken != upd_pred);
    misTaken_d = misPred_d ? upd_taken : misTaken_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predValid_q <= 1'b0;
      misPred_q   <= 1'b0;
      misTaken_q  <= 1'b0;
    end else begin
      predValid_q <= predValid_d;
      misPred_q   <= misPred_d;
      misTaken_q  <= misTaken_d;
    end
  end

  assign pred_valid = predValid_q;
  assign pred_taken = rdCnt[CNT_W-1];
  assign mispredict = misPred_q;
  assign mis_taken  = misTaken_q;

`ifdef BP_PERF_CNT_EN
  logic [31:0] brCnt_q, brCnt_d;
  logic [31:0] missCnt_q, missCnt_d;

  // Both counters wrap modulo 2^32.
  always_comb begin
    brCnt_d   = brCnt_q;
    missCnt_d = missCnt_q;
    if (upd_valid) brCnt_d = brCnt_q + 32'd1;
    if (misPred_d) missCnt_d = missCnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCnt_q   <= '0;
      missCnt_q <= '0;
    end else begin
      brCnt_q   <= brCnt_d;
      missCnt_q <= missCnt_d;
    end
  end

  assign br_cnt   = brCnt_q;
  assign miss_cnt = missCnt_q;
`endif

  // Upper and byte-offset PC bits never reach the table index.
  assign unusedBits = ^{lk_pc[31:IDX_BITS+2], lk_pc[1:0],
                        upd_pc[31:IDX_BITS+2], upd_pc[1:0], rdCnt[0]};

endmodule
